// File: rtl/cache_arbiter.sv
// Round-robin arbiter that shares the single physical-memory port between the
// instruction cache and the data cache, holding the winning request stable until pmem_resp.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic                  i_pmem_resp,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic                  d_pmem_resp,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ICACHE = 2'd1;
  localparam logic [1:0] S_DCACHE = 2'd2;

  logic [1:0]            state;
  logic                  last_grant;
  logic                  req_read;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINE_WIDTH-1:0] req_wdata;

  logic i_pend;
  logic d_pend;
  logic grant_i;
  logic grant_d;
  logic busy;

  assign i_pend = i_pmem_read;
  assign d_pend = d_pmem_read | d_pmem_write;

  // On a tie the side that did not win last time goes next; last_grant=0 favours dcache.
  assign grant_d = d_pend & (~i_pend | ~last_grant);
  assign grant_i = i_pend & ~grant_d;

  assign busy = (state == S_ICACHE) || (state == S_DCACHE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b0;
      req_read   <= 1'b0;
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A simultaneous dcache read+write is treated as a write-back only.
          if (grant_d) begin
            state      <= S_DCACHE;
            last_grant <= 1'b1;
            req_read   <= ~d_pmem_write;
            req_write  <= d_pmem_write;
            req_addr   <= d_pmem_address;
            req_wdata  <= d_pmem_wdata;
          end else if (grant_i) begin
            state      <= S_ICACHE;
            last_grant <= 1'b0;
            req_read   <= 1'b1;
            req_write  <= 1'b0;
            req_addr   <= i_pmem_address;
            req_wdata  <= '0;
          end
        end
        S_ICACHE, S_DCACHE: begin
          if (pmem_resp) begin
            state     <= S_IDLE;
            req_read  <= 1'b0;
            req_write <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pmem_read    = busy & req_read;
  assign pmem_write   = busy & req_write;
  assign pmem_address = req_addr;
  assign pmem_wdata   = req_wdata;

  assign i_pmem_resp  = (state == S_ICACHE) & pmem_resp;
  assign d_pmem_resp  = (state == S_DCACHE) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios followed by random traffic,
// compared against a transaction-level model of who owns the memory port.
module tb_cache_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic          i_pmem_resp;
  logic [LW-1:0] i_pmem_rdata;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic          d_pmem_resp;
  logic [LW-1:0] d_pmem_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_resp    (i_pmem_resp),
    .i_pmem_rdata   (i_pmem_rdata),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_resp    (d_pmem_resp),
    .d_pmem_rdata   (d_pmem_rdata),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_resp      (pmem_resp),
    .pmem_rdata     (pmem_rdata)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  // Transaction-level model: is the port owned, by whom, and what was captured at grant.
  bit          m_busy;
  bit          m_side;      // 0 = icache, 1 = dcache
  bit          m_last;
  bit          m_read;
  bit          m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  bit          m_done_i;
  bit          m_done_d;
  byte         order_q[$];

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle starting at a negedge: check port, optionally pulse pmem_resp, advance model.
  task automatic run_cycle(input bit do_resp, input logic [LW-1:0] rdata);
    bit pi;
    bit pd;
    check("pmem_read", pmem_read, m_busy & m_read);
    check("pmem_write", pmem_write, m_busy & m_write);
    if (m_busy) begin
      check("pmem_address", pmem_address, m_addr);
      check("pmem_wdata", pmem_wdata, m_wdata);
    end
    pmem_resp  = do_resp;
    pmem_rdata = rdata;
    #1;
    check("i_pmem_resp", i_pmem_resp, do_resp & m_busy & ~m_side);
    check("d_pmem_resp", d_pmem_resp, do_resp & m_busy & m_side);
    check("i_pmem_rdata", i_pmem_rdata, rdata);
    check("d_pmem_rdata", d_pmem_rdata, rdata);
    if (i_pmem_resp) order_q.push_back("i");
    if (d_pmem_resp) order_q.push_back("d");
    m_done_i = 1'b0;
    m_done_d = 1'b0;
    if (m_busy) begin
      if (do_resp) begin
        m_busy   = 1'b0;
        m_done_i = ~m_side;
        m_done_d = m_side;
      end
    end else begin
      pi = i_pmem_read;
      pd = d_pmem_read | d_pmem_write;
      if (pi || pd) begin
        m_busy = 1'b1;
        if (pi && pd) m_side = ~m_last;
        else          m_side = pd;
        m_last = m_side;
        if (m_side) begin
          m_write = d_pmem_write;
          m_read  = ~d_pmem_write;
          m_addr  = d_pmem_address;
          m_wdata = d_pmem_wdata;
        end else begin
          m_write = 1'b0;
          m_read  = 1'b1;
          m_addr  = i_pmem_address;
          m_wdata = '0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    pmem_resp = 1'b0;
  endtask

  // Assert reset mid-cycle (optionally with a stray pmem_resp) and release it on a negedge.
  task automatic do_reset(input bit resp_during);
    #2;
    reset     = 1'b1;
    pmem_resp = resp_during;
    #1;
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_i_resp", i_pmem_resp, 1'b0);
    check("rst_d_resp", d_pmem_resp, 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold_read", pmem_read | pmem_write, 1'b0);
    check("rst_hold_resp", i_pmem_resp | d_pmem_resp, 1'b0);
    @(negedge clk);
    reset     = 1'b0;
    pmem_resp = 1'b0;
    m_busy    = 1'b0;
    m_last    = 1'b0;
  endtask

  initial begin
    byte exp_order [4];
    bit  i_act;
    bit  d_act;
    bit  rs;
    int  op;

    reset          = 1'b1;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_resp      = 1'b0;
    pmem_rdata     = '0;
    m_busy         = 1'b0;
    m_last         = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // Lone icache read, then a stray pmem_resp while idle.
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1230;
    run_cycle(1'b0, '0);
    check("i_alone_read", pmem_read, 1'b1);
    check("i_alone_addr", pmem_address, 16'h1230);
    run_cycle(1'b0, '0);
    run_cycle(1'b1, {16{8'hA5}});
    i_pmem_read = 1'b0;
    run_cycle(1'b0, '0);
    run_cycle(1'b1, {16{8'h3C}});
    run_cycle(1'b0, '0);

    // First tie after reset goes to dcache; its address change mid-flight is ignored.
    do_reset(1'b0);
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h4000;
    d_pmem_wdata   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h0010;
    run_cycle(1'b0, '0);
    check("tie_d_write", pmem_write, 1'b1);
    check("tie_d_addr", pmem_address, 16'h4000);
    d_pmem_address = 16'h5000;
    run_cycle(1'b0, '0);
    check("hold_addr", pmem_address, 16'h4000);
    run_cycle(1'b1, {4{32'hDEADBEEF}});
    d_pmem_write = 1'b0;
    run_cycle(1'b0, '0);
    run_cycle(1'b0, '0);
    check("tie_i_addr", pmem_address, 16'h0010);
    run_cycle(1'b1, {4{32'h01020304}});
    i_pmem_read = 1'b0;
    run_cycle(1'b0, '0);

    // Both sides hold requests continuously: grants must alternate d, i, d, i.
    do_reset(1'b0);
    order_q.delete();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h0020;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h6000;
    repeat (4) begin
      run_cycle(1'b0, '0);
      run_cycle(1'b0, '0);
      run_cycle(1'b1, {4{$urandom}});
    end
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    run_cycle(1'b0, '0);
    exp_order = '{"d", "i", "d", "i"};
    check("order_len", order_q.size(), 4);
    for (int k = 0; k < 4 && k < order_q.size(); k++)
      check("order", order_q[k], exp_order[k]);

    // Simultaneous dcache read and write is issued as a write only.
    d_pmem_read    = 1'b1;
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h2220;
    d_pmem_wdata   = {4{32'hCAFEF00D}};
    run_cycle(1'b0, '0);
    check("rw_write", pmem_write, 1'b1);
    check("rw_read", pmem_read, 1'b0);
    run_cycle(1'b1, '0);
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    run_cycle(1'b0, '0);

    // Reset while dcache waits on memory, then the held request is served again.
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h3330;
    run_cycle(1'b0, '0);
    run_cycle(1'b0, '0);
    do_reset(1'b1);
    run_cycle(1'b0, '0);
    check("regrant_read", pmem_read, 1'b1);
    check("regrant_addr", pmem_address, 16'h3330);
    run_cycle(1'b1, {8{16'h7777}});
    d_pmem_read = 1'b0;
    run_cycle(1'b0, '0);

    // Random traffic from both caches with random memory latency.
    i_act = 1'b0;
    d_act = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!i_act && $urandom_range(0, 1) == 1) begin
        i_act          = 1'b1;
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'($urandom);
      end
      if (!d_act && $urandom_range(0, 1) == 1) begin
        d_act          = 1'b1;
        op             = int'($urandom_range(0, 2));
        d_pmem_read    = (op != 1);
        d_pmem_write   = (op != 0);
        d_pmem_address = 16'($urandom);
        d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      if (m_busy) rs = ($urandom_range(0, 2) == 0);
      else        rs = ($urandom_range(0, 7) == 0);
      run_cycle(rs, {$urandom, $urandom, $urandom, $urandom});
      if (m_done_i) begin
        i_act       = 1'b0;
        i_pmem_read = 1'b0;
      end
      if (m_done_d) begin
        d_act        = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates between the instruction cache and the data cache for the single physical-memory port of the LC-3b memory hierarchy. Sits directly downstream of each cache controller's pmem interface and upstream of physical memory. Captures the winning request (op, address, write line) at grant time and holds it stable to memory until `pmem_resp`. Uses round-robin priority when both caches request together.

## Interface
- `ADDR_WIDTH`, 16, byte address width (lc3b_word)
- `LINE_WIDTH`, 128, cache line width in bits (lc3b_line)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `i_pmem_read`  in  1  icache line read request, held until `i_pmem_resp`
- `i_pmem_address`  in  ADDR_WIDTH  icache line address
- `i_pmem_resp`  out  1  icache request complete
- `i_pmem_rdata`  out  LINE_WIDTH  line returned to icache
- `d_pmem_read`  in  1  dcache line read request, held until `d_pmem_resp`
- `d_pmem_write`  in  1  dcache line write-back request, held until `d_pmem_resp`
- `d_pmem_address`  in  ADDR_WIDTH  dcache line address
- `d_pmem_wdata`  in  LINE_WIDTH  dcache line to write back
- `d_pmem_resp`  out  1  dcache request complete
- `d_pmem_rdata`  out  LINE_WIDTH  line returned to dcache
- `pmem_read`  out  1  read request to physical memory
- `pmem_write`  out  1  write request to physical memory
- `pmem_address`  out  ADDR_WIDTH  latched request address
- `pmem_wdata`  out  LINE_WIDTH  latched write line
- `pmem_resp`  in  1  physical memory done (single-cycle pulse)
- `pmem_rdata`  in  LINE_WIDTH  read line, valid when `pmem_resp`=1

## Operation
- States: `s_idle`, `s_icache`, `s_dcache`.
- Registers: `state`, `last_grant` (0=icache, 1=dcache), `req_read`, `req_write`, `req_addr`, `req_wdata`.
- `s_idle`: no pmem request driven. Pending requests are `i_pend = i_pmem_read` and `d_pend = d_pmem_read | d_pmem_write`.
  - Only one pending: grant it.
  - Both pending: grant the one not equal to `last_grant`.
  - On grant, latch address, wdata and op, update `last_grant`, and move to the granted state.
  - If `d_pmem_read` and `d_pmem_write` are both high, the write wins and is latched as a write only.
  - Icache grants latch `req_write`=0 and `req_wdata`=0.
- `s_icache` / `s_dcache`:
  - Drive `pmem_read=req_read`, `pmem_write=req_write`, `pmem_address=req_addr`, `pmem_wdata=req_wdata` from registers only. Input changes after grant are ignored.
  - When `pmem_resp`=1, assert the granted side's `*_pmem_resp` combinationally in the same cycle, then return to `s_idle`.
  - The other side's resp stays 0.
- `i_pmem_rdata` and `d_pmem_rdata` always equal `pmem_rdata`. Consumers qualify the data with their own resp.
- No request is ever dropped. A requester that is not granted keeps waiting with its signals held.

## Timing
- Reset (async assert, takes effect immediately): `state=s_idle`, `last_grant=0` (so dcache wins the first tie), request registers cleared.
  - While reset is asserted: all pmem outputs 0 and both resps 0.
- Reset asserted mid-transaction: the pmem request drops at once, the transaction is abandoned, and no resp is issued.
- Grant latency: a request seen in `s_idle` at edge N appears on pmem outputs after edge N, i.e. one cycle after the request rises.
- Completion: `*_pmem_resp` is high in the same cycle as `pmem_resp`, for exactly one cycle. The FSM is in `s_idle` the following cycle.
- Minimum turnaround: one `s_idle` cycle between consecutive pmem transactions. `pmem_read`/`pmem_write` deassert for at least one cycle after every `pmem_resp`.
- Back-to-back ties alternate strictly: d, i, d, i, …
- `pmem_resp` arriving in `s_idle` is ignored and produces no cache resp.

## Test plan
- Reset, then `i_pmem_read`=1 with addr 0x1230 alone.
  - Required: `pmem_read`=1 and `pmem_address`=0x1230 from the next cycle.
  - After `pmem_resp` with rdata 0xA5…A5: `i_pmem_resp`=1 for 1 cycle with `i_pmem_rdata`=0xA5…A5, and `d_pmem_resp`=0.
- Both caches request in the same cycle right after reset (d write to 0x4000, wdata 0x0123…, i read 0x0010).
  - Required: dcache is served first (`pmem_write`=1, addr 0x4000), then one idle cycle, then the icache read of 0x0010.
- Both caches hold requests continuously for 4 transactions.
  - Required: grant order is d, i, d, i, with `pmem_read`/`pmem_write` low for one cycle between each.
- Dcache changes `d_pmem_address` from 0x4000 to 0x5000 mid-transaction.
  - Required: `pmem_address` stays 0x4000 until `pmem_resp`.
- `d_pmem_read` and `d_pmem_write` both high.
  - Required: `pmem_write`=1 and `pmem_read`=0.
- Assert `reset` while `s_dcache` is waiting on pmem.
  - Required: all pmem outputs go to 0 immediately, and no `d_pmem_resp` is issued.
  - After release with the request still held: the request is re-granted and completes normally.
